// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (bit period, data width, parity, stop bits) with ready/valid input
//   clk_i       system clock, rising edge
//   reset_i     synchronous active-high reset
//   data_in_i   word to send, latched on acceptance
//   tx_start_i  valid; accepted when tx_ready_o is high
//   tx_ready_o  high when a new word can be accepted
//   tx_o        serial line, idle high, LSB first
//   tx_done_o   one-cycle pulse as the last stop bit ends
module uart_tx_cfg #(
  parameter int CLK_PER_BIT = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DATA_BITS-1:0] data_in_i,
  input  logic                 tx_start_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 tx_done_o
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 stp_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;
  logic                 wrap;
  assign wrap = cnt_q == CW'(CLK_PER_BIT - 1);
  // Each wrap edge loads the level of the next frame bit, so tx_o is always registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stp_q      <= 1'b0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      tx_o       <= 1'b1;
      tx_ready_o <= 1'b1;
      tx_done_o  <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      cnt_q     <= (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          tx_o       <= 1'b1;
          tx_ready_o <= 1'b1;
          if (tx_start_i) begin
            state_q    <= START;
            tx_o       <= 1'b0;
            tx_ready_o <= 1'b0;
            sh_q       <= data_in_i;
            par_q      <= (^data_in_i) ^ (PARITY == 2);
          end
        end
        START: if (wrap) begin
          state_q <= DATA;
          tx_o    <= sh_q[0];
          sh_q    <= sh_q >> 1;
          idx_q   <= '0;
        end
        DATA: if (wrap) begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            state_q <= (PARITY != 0) ? PAR : STOP;
            tx_o    <= (PARITY != 0) ? par_q : 1'b1;
            stp_q   <= 1'b0;
          end else begin
            tx_o <= sh_q[0];
            sh_q <= sh_q >> 1;
          end
        end
        PAR: if (wrap) begin
          state_q <= STOP;
          tx_o    <= 1'b1;
          stp_q   <= 1'b0;
        end
        STOP: if (wrap) begin
          if (stp_q == 1'(STOP_BITS - 1)) begin
            state_q    <= IDLE;
            tx_ready_o <= 1'b1;
            tx_done_o  <= 1'b1;
          end else begin
            stp_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_o       <= 1'b1;
          tx_ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed table-driven bench for uart_tx_cfg in 8N1, 7E1, 7O1 and 8O2 builds
module tb_uart_tx_cfg;
  localparam int C = 16;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] st  = '0;
  logic [7:0] da  = '0;
  logic [6:0] db  = '0;
  logic [6:0] dc  = '0;
  logic [7:0] dd  = '0;
  logic [3:0] tx_w, rdy_w, dn_w;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         nd0   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (dn_w[0]) nd0 <= nd0 + 1;
  uart_tx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk_i(clk), .reset_i(rst), .data_in_i(da), .tx_start_i(st[0]),
    .tx_ready_o(rdy_w[0]), .tx_o(tx_w[0]), .tx_done_o(dn_w[0]));
  uart_tx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk_i(clk), .reset_i(rst), .data_in_i(db), .tx_start_i(st[1]),
    .tx_ready_o(rdy_w[1]), .tx_o(tx_w[1]), .tx_done_o(dn_w[1]));
  uart_tx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk_i(clk), .reset_i(rst), .data_in_i(dc), .tx_start_i(st[2]),
    .tx_ready_o(rdy_w[2]), .tx_o(tx_w[2]), .tx_done_o(dn_w[2]));
  uart_tx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u3 (
    .clk_i(clk), .reset_i(rst), .data_in_i(dd), .tx_start_i(st[3]),
    .tx_ready_o(rdy_w[3]), .tx_o(tx_w[3]), .tx_done_o(dn_w[3]));
  typedef struct {
    int          u;
    logic [7:0]  v;
    logic [11:0] e;
    int          n;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic set_in(input int u, input logic s, input logic [7:0] v);
    st[u] = s;
    case (u)
      0: da = v;
      1: db = v[6:0];
      2: dc = v[6:0];
      default: dd = v;
    endcase
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic frame_check(input int u, input logic [11:0] exp, input int n, input int poke, input string nm);
    logic [11:0] cap = '0;
    bit glitch = 0;
    bit busy = 0;
    for (int c = 0; c < n * C; c++) begin
      if (c == poke) set_in(u, 1'b1, 8'hC3);
      if (c == poke + 1) set_in(u, 1'b0, 8'hC3);
      if (tx_w[u] !== exp[c / C]) glitch = 1;
      if (c % C == C / 2) cap[c / C] = tx_w[u];
      if (rdy_w[u] !== 1'b0 || dn_w[u] !== 1'b0) busy = 1;
      step();
    end
    chk({nm, " bits"}, 32'(cap), 32'(exp));
    chk({nm, " bit_hold"}, 32'(glitch), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " end"}, {29'd0, tx_w[u], rdy_w[u], dn_w[u]}, 32'b111);
  endtask
  task automatic run_frame(input int u, input logic [7:0] v, input logic [11:0] exp, input int n, input int poke, input string nm);
    set_in(u, 1'b1, v);
    step();
    set_in(u, 1'b0, ~v);
    frame_check(u, exp, n, poke, nm);
    step();
    chk({nm, " idle"}, {29'd0, tx_w[u], rdy_w[u], dn_w[u]}, 32'b110);
  endtask
  initial begin
    int n0;
    bit bad;
    tbl[0]  = '{0, 8'hA5, 12'h34A, 10};
    tbl[1]  = '{0, 8'h00, 12'h200, 10};
    tbl[2]  = '{0, 8'hFF, 12'h3FE, 10};
    tbl[3]  = '{0, 8'h3C, 12'h278, 10};
    tbl[4]  = '{1, 8'h07, 12'h30E, 10};
    tbl[5]  = '{2, 8'h07, 12'h20E, 10};
    tbl[6]  = '{1, 8'h55, 12'h2AA, 10};
    tbl[7]  = '{2, 8'h55, 12'h3AA, 10};
    tbl[8]  = '{3, 8'hA5, 12'hF4A, 12};
    tbl[9]  = '{3, 8'h00, 12'hE00, 12};
    tbl[10] = '{3, 8'h01, 12'hC02, 12};
    repeat (3) step();
    for (int u = 0; u < 4; u++) chk($sformatf("reset u%0d", u), {29'd0, tx_w[u], rdy_w[u], dn_w[u]}, 32'b110);
    rst = 1'b0;
    step();
    for (int i = 0; i < 11; i++) run_frame(tbl[i].u, tbl[i].v, tbl[i].e, tbl[i].n, -10, $sformatf("vec%0d", i));
    n0 = nd0;
    set_in(0, 1'b1, 8'h10);
    for (int j = 0; j < 3; j++) begin
      step();
      set_in(0, j < 2, 8'(8'h11 + j));
      frame_check(0, 12'h220 + 12'(2 * j), 10, -10, $sformatf("b2b%0d", j));
    end
    step();
    chk("b2b idle", {29'd0, tx_w[0], rdy_w[0], dn_w[0]}, 32'b110);
    chk("b2b done_count", 32'(nd0 - n0), 3);
    run_frame(0, 8'hA5, 12'h34A, 10, 40, "midpoke");
    bad = 0;
    repeat (30) begin
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) bad = 1;
      step();
    end
    chk("midpoke no_extra", 32'(bad), 0);
    set_in(0, 1'b1, 8'hA5);
    step();
    set_in(0, 1'b0, 8'h00);
    repeat (70) @(posedge clk);
    #1;
    chk("rst data_bit3", 32'(tx_w[0]), 0);
    rst = 1'b1;
    step();
    chk("rst midframe", {29'd0, tx_w[0], rdy_w[0], dn_w[0]}, 32'b110);
    rst = 1'b0;
    n0 = nd0;
    bad = 0;
    repeat (20) begin
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || dn_w[0] !== 1'b0) bad = 1;
      step();
    end
    chk("rst quiet", 32'(bad), 0);
    chk("rst no_done", 32'(nd0 - n0), 0);
    run_frame(0, 8'h3C, 12'h278, 10, -10, "after_rst");
    rst = 1'b1;
    set_in(0, 1'b1, 8'h5A);
    step();
    rst = 1'b0;
    set_in(0, 1'b0, 8'h5A);
    chk("rst_start edge", {29'd0, tx_w[0], rdy_w[0], dn_w[0]}, 32'b110);
    step();
    chk("rst_start none", {29'd0, tx_w[0], rdy_w[0], dn_w[0]}, 32'b110);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
